wb_register_file: RTL and testbench

Architectural register file for the five-stage MIPS pipeline, sitting at the consuming end of the MEM/WB pipeline register. It takes the writeback controls and data from MEM/WB, selects the writeback value, and commits it to one of 32 × 32-bit registers. It serves two asynchronous read ports to the ID stage and one debug read port. An optional internal bypass lets ID see the value being written back in the same cycle.

---
 rtl/wb_register_file.sv | 70 +++++++
 tb/tb_wb_register_file.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_register_file.sv
// MIPS writeback-stage register file: 32 x DATA_W registers, two async ID read ports, one debug port.
// Optional same-cycle WB->ID bypass is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] read_memory,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [ADDR_W-1:0] reg_dst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_count
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [31:0]       wb_count_q;
    logic              wr_en;

    assign wb_data  = MemtoReg ? read_memory : ALU_result;
    // Writes to $0 are dropped entirely, so they must not bump the counter either.
    assign wr_en    = RegWrite && (reg_dst != '0);
    assign wb_count = wb_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wb_count_q <= '0;
        end else if (wr_en) begin
            regs[reg_dst] <= wb_data;
            wb_count_q    <= wb_count_q + 32'd1;
        end
    end

    // $0 is forced to zero on read so it never depends on register contents.
    always_comb begin
        rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
`ifdef WB_REGFILE_BYPASS_EN
        if (wr_en && (rs_addr == reg_dst)) begin
            rs_data = wb_data;
        end
`endif
    end

    always_comb begin
        rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef WB_REGFILE_BYPASS_EN
        if (wr_en && (rt_addr == reg_dst)) begin
            rt_data = wb_data;
        end
`endif
    end

    always_comb begin
        dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: directed cases plus randomized traffic vs. an array model.
module tb_wb_register_file;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic        MemtoReg;
    logic [31:0] read_memory;
    logic [31:0] ALU_result;
    logic [4:0]  reg_dst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dbg_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] dbg_data;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_count;
    int          checks = 0;
    int          errors = 0;

    wb_register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .read_memory (read_memory),
        .ALU_result  (ALU_result),
        .reg_dst     (reg_dst),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .dbg_addr    (dbg_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .dbg_data    (dbg_data),
        .wb_data     (wb_data),
        .wb_count    (wb_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        return MemtoReg ? read_memory : ALU_result;
    endfunction

    // ID ports may see the in-flight write; the debug port never does.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit id_port);
        if (a == 5'd0) return 32'd0;
        if (id_port && BYPASS && RegWrite && reg_dst != 5'd0 && a == reg_dst) return exp_wb();
        return mdl_regs[a];
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".wb_data"},  wb_data,  exp_wb());
        check_eq({tag, ".rs_data"},  rs_data,  exp_read(rs_addr, 1'b1));
        check_eq({tag, ".rt_data"},  rt_data,  exp_read(rt_addr, 1'b1));
        check_eq({tag, ".dbg_data"}, dbg_data, exp_read(dbg_addr, 1'b0));
        check_eq({tag, ".wb_count"}, wb_count, mdl_count);
    endtask

    task automatic drive(input logic rst, input logic rw, input logic m2r, input logic [31:0] rm,
                         input logic [31:0] alu, input logic [4:0] dst, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] dbg);
        reset = rst; RegWrite = rw; MemtoReg = m2r; read_memory = rm; ALU_result = alu;
        reg_dst = dst; rs_addr = rs; rt_addr = rt; dbg_addr = dbg;
        #1;
    endtask

    // One clock edge; the model commits with the same rules, then we return at the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
            mdl_count = 32'd0;
        end else if (RegWrite && reg_dst != 5'd0) begin
            mdl_regs[reg_dst] = exp_wb();
            mdl_count = mdl_count + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
        mdl_count = 32'd0;
        @(negedge clk);

        // Initial reset
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 32'h1, 32'h2, 0, 5'd1, 5'd31, 5'd15);
        check_all("reset_init");
        check_eq("reset_init.count_const", wb_count, 32'd0);

        // Writeback mux: load data then ALU data to $7
        drive(0, 1, 1, 32'h12345678, 32'hAAAA0000, 5'd7, 5'd7, 5'd7, 5'd7);
        check_all("mux_mem_pre");
        check_eq("mux_mem_wb", wb_data, 32'h12345678);
        step();
        drive(0, 0, 1, 32'h12345678, 32'hAAAA0000, 5'd7, 5'd7, 5'd7, 5'd7);
        check_eq("mux_mem_dbg", dbg_data, 32'h12345678);
        check_eq("mux_mem_cnt", wb_count, 32'd1);
        drive(0, 1, 0, 32'h12345678, 32'hAAAA0000, 5'd7, 5'd0, 5'd7, 5'd7);
        check_eq("mux_alu_wb", wb_data, 32'hAAAA0000);
        step();
        drive(0, 0, 0, 32'h12345678, 32'hAAAA0000, 5'd7, 5'd7, 5'd7, 5'd7);
        check_eq("mux_alu_dbg", dbg_data, 32'hAAAA0000);
        check_eq("mux_alu_cnt", wb_count, 32'd2);
        check_all("mux_alu_post");

        // $0 protection, including same-cycle read in bypass build
        drive(0, 1, 0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        check_eq("zero_pre_rs", rs_data, 32'd0);
        check_eq("zero_pre_rt", rt_data, 32'd0);
        step();
        drive(0, 0, 0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        check_eq("zero_post_rs", rs_data, 32'd0);
        check_eq("zero_post_cnt", wb_count, 32'd2);

        // Same-cycle read/write on $9
        drive(0, 1, 0, 32'h0, 32'h1, 5'd9, 5'd1, 5'd2, 5'd3);
        step();
        drive(0, 1, 0, 32'h0, 32'h2, 5'd9, 5'd9, 5'd9, 5'd9);
        check_eq("rw_same_rs", rs_data, BYPASS ? 32'h2 : 32'h1);
        check_eq("rw_same_rt", rt_data, BYPASS ? 32'h2 : 32'h1);
        check_eq("rw_same_dbg", dbg_data, 32'h1);
        check_all("rw_same_pre");
        step();
        drive(0, 0, 0, 32'h0, 32'h2, 5'd9, 5'd9, 5'd9, 5'd9);
        check_eq("rw_after_rs", rs_data, 32'h2);
        check_eq("rw_after_rt", rt_data, 32'h2);
        check_eq("rw_after_dbg", dbg_data, 32'h2);

        // RegWrite=0 leaves $3 and the counter alone
        drive(0, 1, 0, 32'h0, 32'h33, 5'd3, 5'd0, 5'd0, 5'd3);
        step();
        drive(0, 0, 1, 32'h5555AAAA, 32'h77, 5'd3, 5'd3, 5'd3, 5'd3);
        step();
        check_eq("nowr_dbg", dbg_data, 32'h33);
        check_all("nowr_post");

        // Counter wrap via backdoor preload
        force dut.wb_count_q = 32'hFFFFFFFF;
        #1;
        release dut.wb_count_q;
        mdl_count = 32'hFFFFFFFF;
        drive(0, 1, 0, 32'h0, 32'hC0FFEE, 5'd12, 5'd12, 5'd0, 5'd12);
        check_eq("wrap_pre", wb_count, 32'hFFFFFFFF);
        step();
        check_eq("wrap_post", wb_count, 32'd0);
        check_eq("wrap_data", dbg_data, 32'hC0FFEE);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) rt_addr = rs_addr;
            if ($urandom_range(0, 3) == 0) rs_addr = reg_dst;
            #1;
            check_all("rand_pre");
            step();
        end

        // Reset after arbitrary writes: hold two edges, then sweep every register
        drive(0, 1, 1, 32'h0BADF00D, 32'h0, 5'd20, 5'd0, 5'd0, 5'd0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a), 5'(a));
            check_eq("reset_sweep_rs", rs_data, 32'd0);
            check_eq("reset_sweep_rt", rt_data, 32'd0);
            check_eq("reset_sweep_dbg", dbg_data, 32'd0);
        end
        check_eq("reset_sweep_cnt", wb_count, 32'd0);

        // Reset wins over a simultaneous write
        drive(0, 1, 0, 32'h0, 32'h55, 5'd5, 5'd0, 5'd0, 5'd5);
        step();
        drive(1, 1, 0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 5'd5);
        step();
        drive(0, 0, 0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 5'd5);
        check_eq("reset_wins_rs", rs_data, 32'd0);
        check_eq("reset_wins_dbg", dbg_data, 32'd0);
        check_eq("reset_wins_cnt", wb_count, 32'd0);
        check_all("reset_wins");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
